// File: rtl/fv_bank_req_arbiter.sv
// Feature-value bank request arbiter: round-robin Edge PE reads vs. write-back bursts,
// with starvation guard for reads and sticky protocol error detection.

module fv_bank_req_lane #(
  parameter int PTR_W = 2,
  parameter int LANE  = 0
) (
  input  logic             req_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             hi_req
);
  // Request sits at or above the round-robin pointer, so it ranks ahead of wrapped ones.
  assign hi_req = req_valid && (PTR_W'(LANE) >= rr_ptr);
endmodule

module fv_bank_req_arbiter #(
  parameter int NUM_PE       = 4,
  parameter int NODE_ID_W    = 10,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          phase_en,
  input  logic [NUM_PE-1:0]             pe_req_valid,
  input  logic [NUM_PE*NODE_ID_W-1:0]   pe_req_node_id,
  output logic [NUM_PE-1:0]             pe_req_ready,
  input  logic                          wb_valid,
  input  logic                          wb_eos,
  input  logic [NODE_ID_W-1:0]          wb_node_id,
  input  logic [DATA_W-1:0]             wb_data,
  output logic                          wb_ready,
  input  logic                          bank_available,
  input  logic                          rd_eos,
  output logic                          bank_req_valid,
  output logic                          bank_req_rd_wr,
  output logic                          bank_req_wr_eos,
  output logic [NODE_ID_W-1:0]          bank_req_node_id,
  output logic [DATA_W-1:0]             bank_req_data,
  output logic [$clog2(NUM_PE)-1:0]     bank_req_pe_tag,
  output logic                          protocol_err
);
  localparam int PTR_W = $clog2(NUM_PE);
  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_BURST} state_t;

  state_t                           state_q, state_d;
  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]                 starve_q, starve_d;
  logic [NODE_ID_W-1:0]             wb_id_q, wb_id_d;
  logic                             perr_q, perr_d;

  logic [NUM_PE-1:0]                hi_req;
  logic [NUM_PE-1:0][NODE_ID_W-1:0] pe_ids;
  logic [PTR_W-1:0]                 rd_win;
  logic                             any_rd;
  logic                             starve_hit;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    fv_bank_req_lane #(.PTR_W(PTR_W), .LANE(i)) u_lane (
      .req_valid (pe_req_valid[i]),
      .rr_ptr    (rr_ptr_q),
      .hi_req    (hi_req[i])
    );
    assign pe_ids[i] = pe_req_node_id[i*NODE_ID_W +: NODE_ID_W];
  end

  assign any_rd     = |pe_req_valid;
  assign starve_hit = (starve_q == STARVE_MAX) && any_rd;

  // Lowest valid index overall, overridden by lowest valid index at/after rr_ptr.
  always_comb begin
    rd_win = '0;
    for (int i = NUM_PE-1; i >= 0; i--)
      if (pe_req_valid[i]) rd_win = PTR_W'(i);
    for (int i = NUM_PE-1; i >= 0; i--)
      if (hi_req[i]) rd_win = PTR_W'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      starve_q <= '0;
      wb_id_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      wb_id_q  <= wb_id_d;
      perr_q   <= perr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    starve_d         = starve_q;
    wb_id_d          = wb_id_q;
    perr_d           = perr_q;
    pe_req_ready     = '0;
    wb_ready         = 1'b0;
    bank_req_valid   = 1'b0;
    bank_req_rd_wr   = 1'b0;
    bank_req_wr_eos  = 1'b0;
    bank_req_node_id = '0;
    bank_req_data    = '0;
    bank_req_pe_tag  = '0;

    if (rd_eos && state_q != RD_WAIT) perr_d = 1'b1;

    // Outputs stay silent in any cycle reset is high.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (!any_rd) starve_d = '0;
          if (phase_en && bank_available) begin
            if (wb_valid && !starve_hit) begin
              bank_req_valid   = 1'b1;
              bank_req_rd_wr   = 1'b1;
              bank_req_wr_eos  = wb_eos;
              bank_req_node_id = wb_node_id;
              bank_req_data    = wb_data;
              wb_ready         = 1'b1;
              wb_id_d          = wb_node_id;
              state_d          = wb_eos ? IDLE : WR_BURST;
              if (any_rd && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
            end else if (any_rd) begin
              bank_req_valid       = 1'b1;
              bank_req_node_id     = pe_ids[rd_win];
              bank_req_pe_tag      = rd_win;
              pe_req_ready[rd_win] = 1'b1;
              rr_ptr_d             = rd_win + 1'b1;
              starve_d             = '0;
              state_d              = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (rd_eos) state_d = IDLE;
        end
        WR_BURST: begin
          if (wb_valid) begin
            bank_req_valid   = 1'b1;
            bank_req_rd_wr   = 1'b1;
            bank_req_wr_eos  = wb_eos;
            bank_req_node_id = wb_id_q;
            bank_req_data    = wb_data;
            wb_ready         = 1'b1;
            if (wb_node_id != wb_id_q) perr_d = 1'b1;
            if (wb_eos) state_d = IDLE;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign protocol_err = perr_q;

endmodule
